// File: rtl/ddr3_reset_sequencer.sv
// DDR3 power-up / recovery sequencer: qualifies PLL lock, starts the memory
// clock, pulses the controller reset, waits for calibration and only then
// releases the system reset. Retries or faults on calibration timeout/loss.
module ddr3_reset_sequencer #(
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned STOP_CYCLES    = 16,
    parameter int unsigned DDR_RST_CYCLES = 64,
    parameter int unsigned CALIB_TIMEOUT  = 1048576,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk50,
    input  logic       cpu_reset,
    input  logic       pll_lock,
    input  logic       ddr3_pll_stop,
    input  logic       init_calib_complete,
    output logic       ddr3_clk_en,
    output logic       ddr_ctrl_rst_n,
    output logic       sys_rst_n,
    output logic [2:0] seq_state,
    output logic [1:0] retry_count,
    output logic       fault
);

    localparam int unsigned MAX_AB  = (LOCK_FILTER > STOP_CYCLES) ? LOCK_FILTER : STOP_CYCLES;
    localparam int unsigned MAX_CD  = (DDR_RST_CYCLES > CALIB_TIMEOUT) ? DDR_RST_CYCLES : CALIB_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TIMER_W = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam int unsigned SYNC_W  = 3;

    localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_FILTER - 1);
    localparam logic [TIMER_W-1:0] STOP_LAST  = TIMER_W'(STOP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RST_LAST   = TIMER_W'(DDR_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CALIB_LAST = TIMER_W'(CALIB_TIMEOUT - 1);
    localparam logic [1:0]         RETRY_MAX  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        CLK_ON    = 3'd1,
        CTRL_RST  = 3'd2,
        CALIB     = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd7
    } state_t;

    // Synchronizer stages, bit order {calib, pll_stop, lock}
    logic [SYNC_W-1:0]  sync_meta;
    logic [SYNC_W-1:0]  sync_out;
    logic               pll_lock_s;
    logic               ddr3_pll_stop_s;
    logic               init_calib_complete_s;

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [1:0]         retry_q;
    logic [1:0]         retry_nxt;
    logic [1:0]         retry_inc;
    logic               clk_en_nxt;
    logic               ctrl_rst_n_nxt;
    logic               sys_rst_n_nxt;
    logic               fault_nxt;

    assign pll_lock_s            = sync_out[0];
    assign ddr3_pll_stop_s       = sync_out[1];
    assign init_calib_complete_s = sync_out[2];

    // Two-flop synchronizers for the three asynchronous inputs
    always_ff @(posedge clk50 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= {init_calib_complete, ddr3_pll_stop, pll_lock};
            sync_out  <= sync_meta;
        end
    end

    // Next-state, timer, retry and registered-output decode
    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        retry_nxt      = retry_q;
        retry_inc      = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
        clk_en_nxt     = 1'b0;
        ctrl_rst_n_nxt = 1'b0;
        sys_rst_n_nxt  = 1'b0;
        fault_nxt      = 1'b0;

        case (state)
            WAIT_LOCK: begin
                if (!pll_lock_s) begin
                    timer_nxt = '0;
                end else if (timer == LOCK_LAST) begin
                    state_nxt = CLK_ON;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            CLK_ON: begin
                if (!pll_lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (timer == STOP_LAST) begin
                    state_nxt = CTRL_RST;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            CTRL_RST: begin
                if (!pll_lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (timer == RST_LAST) begin
                    state_nxt = CALIB;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            CALIB: begin
                if (!pll_lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (init_calib_complete_s) begin
                    state_nxt = RUN;
                end else if (timer == CALIB_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAULT : WAIT_LOCK;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            RUN: begin
                if (!pll_lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (!init_calib_complete_s) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAULT : WAIT_LOCK;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        // Single timer restarts on every state entry
        if (state_nxt != state) begin
            timer_nxt = '0;
        end

        // Outputs follow the state being entered so they change on that edge
        case (state_nxt)
            CLK_ON: begin
                clk_en_nxt = 1'b1;
            end
            CTRL_RST: begin
                clk_en_nxt = 1'b1;
            end
            CALIB: begin
                clk_en_nxt     = ~ddr3_pll_stop_s;
                ctrl_rst_n_nxt = 1'b1;
            end
            RUN: begin
                clk_en_nxt     = ~ddr3_pll_stop_s;
                ctrl_rst_n_nxt = 1'b1;
                sys_rst_n_nxt  = 1'b1;
            end
            FAULT: begin
                fault_nxt = 1'b1;
            end
            default: begin
                clk_en_nxt = 1'b0;
            end
        endcase
    end

    // State, timer, retry counter and output registers
    always_ff @(posedge clk50 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state          <= WAIT_LOCK;
            timer          <= '0;
            retry_q        <= '0;
            ddr3_clk_en    <= 1'b0;
            ddr_ctrl_rst_n <= 1'b0;
            sys_rst_n      <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            retry_q        <= retry_nxt;
            ddr3_clk_en    <= clk_en_nxt;
            ddr_ctrl_rst_n <= ctrl_rst_n_nxt;
            sys_rst_n      <= sys_rst_n_nxt;
            fault          <= fault_nxt;
        end
    end

    assign seq_state   = state;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_ddr3_reset_sequencer.sv
// Directed bench for ddr3_reset_sequencer: a vector table for the nominal,
// lock-loss and calibration-loss sequence, plus hand sequences for lock glitch,
// clock stop, calibration timeout to fault and asynchronous reset.
module tb_ddr3_reset_sequencer;

    typedef struct packed {
        logic       clk_en;
        logic       ctrl_rst_n;
        logic       sys_rst_n;
        logic [2:0] state;
        logic [1:0] retry;
        logic       fault;
    } outs_t;

    typedef struct packed {
        logic [15:0] at;
        logic        lock;
        logic        stop;
        logic        calib;
        outs_t       exp;
    } vec_t;

    logic       clk50;
    logic       cpu_reset;
    logic       pll_lock;
    logic       ddr3_pll_stop;
    logic       init_calib_complete;
    logic       ddr3_clk_en;
    logic       ddr_ctrl_rst_n;
    logic       sys_rst_n;
    logic [2:0] seq_state;
    logic [1:0] retry_count;
    logic       fault;

    int         checks;
    int         errors;
    int         edge_cnt;
    int         base;
    vec_t       vq[$];

    ddr3_reset_sequencer #(
        .LOCK_FILTER   (8),
        .STOP_CYCLES   (4),
        .DDR_RST_CYCLES(6),
        .CALIB_TIMEOUT (100),
        .MAX_RETRIES   (2)
    ) dut (
        .clk50              (clk50),
        .cpu_reset          (cpu_reset),
        .pll_lock           (pll_lock),
        .ddr3_pll_stop      (ddr3_pll_stop),
        .init_calib_complete(init_calib_complete),
        .ddr3_clk_en        (ddr3_clk_en),
        .ddr_ctrl_rst_n     (ddr_ctrl_rst_n),
        .sys_rst_n          (sys_rst_n),
        .seq_state          (seq_state),
        .retry_count        (retry_count),
        .fault              (fault)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    // Free-running edge counter; scenario times are relative to reset release
    initial edge_cnt = 0;
    always @(posedge clk50) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic outs_t o(input logic ce, input logic cr, input logic sr,
                                input logic [2:0] st, input logic [1:0] rc, input logic f);
        outs_t r;
        r.clk_en     = ce;
        r.ctrl_rst_n = cr;
        r.sys_rst_n  = sr;
        r.state      = st;
        r.retry      = rc;
        r.fault      = f;
        return r;
    endfunction

    task automatic add_vec(input int at, input logic l, input logic s, input logic c, input outs_t e);
        vec_t v;
        v.at    = 16'(at);
        v.lock  = l;
        v.stop  = s;
        v.calib = c;
        v.exp   = e;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input outs_t e);
        outs_t a;
        a = {ddr3_clk_en, ddr_ctrl_rst_n, sys_rst_n, seq_state, retry_count, fault};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @rel %0d: got clk_en=%b ctrl=%b sys=%b state=%0d retry=%0d fault=%b, want clk_en=%b ctrl=%b sys=%b state=%0d retry=%0d fault=%b",
                     name, edge_cnt - base, a.clk_en, a.ctrl_rst_n, a.sys_rst_n, a.state, a.retry, a.fault,
                     e.clk_en, e.ctrl_rst_n, e.sys_rst_n, e.state, e.retry, e.fault);
        end
    endtask

    task automatic wait_rel(input int n);
        while (edge_cnt - base < n) @(negedge clk50);
    endtask

    task automatic chk_at(input string name, input int n, input outs_t e);
        wait_rel(n);
        check(name, e);
    endtask

    // Hold reset for a few cycles, then release on a falling edge
    task automatic do_reset(input logic l, input logic s, input logic c);
        @(negedge clk50);
        cpu_reset           = 1'b0;
        pll_lock            = l;
        ddr3_pll_stop       = s;
        init_calib_complete = c;
        repeat (3) @(negedge clk50);
        cpu_reset = 1'b1;
        base      = edge_cnt;
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        base                = 0;
        cpu_reset           = 1'b0;
        pll_lock            = 1'b0;
        ddr3_pll_stop       = 1'b0;
        init_calib_complete = 1'b0;

        // Nominal, lock loss in RUN with full restart, calibration loss in RUN
        add_vec( 0, 1, 0, 0, o(0, 0, 0, 3'd0, 2'd0, 0));
        add_vec( 9, 1, 0, 0, o(0, 0, 0, 3'd0, 2'd0, 0));
        add_vec(10, 1, 0, 0, o(1, 0, 0, 3'd1, 2'd0, 0));
        add_vec(13, 1, 0, 0, o(1, 0, 0, 3'd1, 2'd0, 0));
        add_vec(14, 1, 0, 0, o(1, 0, 0, 3'd2, 2'd0, 0));
        add_vec(19, 1, 0, 0, o(1, 0, 0, 3'd2, 2'd0, 0));
        add_vec(20, 1, 0, 0, o(1, 1, 0, 3'd3, 2'd0, 0));
        add_vec(30, 1, 0, 1, o(1, 1, 0, 3'd3, 2'd0, 0));
        add_vec(32, 1, 0, 1, o(1, 1, 0, 3'd3, 2'd0, 0));
        add_vec(33, 1, 0, 1, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(40, 0, 0, 1, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(42, 0, 0, 1, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(43, 1, 0, 1, o(0, 0, 0, 3'd0, 2'd0, 0));
        add_vec(52, 1, 0, 1, o(0, 0, 0, 3'd0, 2'd0, 0));
        add_vec(53, 1, 0, 1, o(1, 0, 0, 3'd1, 2'd0, 0));
        add_vec(57, 1, 0, 1, o(1, 0, 0, 3'd2, 2'd0, 0));
        add_vec(63, 1, 0, 1, o(1, 1, 0, 3'd3, 2'd0, 0));
        add_vec(64, 1, 0, 1, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(66, 1, 0, 0, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(68, 1, 0, 0, o(1, 1, 1, 3'd4, 2'd0, 0));
        add_vec(69, 1, 0, 0, o(0, 0, 0, 3'd0, 2'd1, 0));

        do_reset(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < vq.size(); i++) begin
            wait_rel(int'(vq[i].at));
            check($sformatf("vec%0d", i), vq[i].exp);
            pll_lock            = vq[i].lock;
            ddr3_pll_stop       = vq[i].stop;
            init_calib_complete = vq[i].calib;
        end

        // Lock glitch: 5 high, 1 low, then high restarts the filter
        do_reset(1'b0, 1'b0, 1'b0);
        pll_lock = 1'b1;
        wait_rel(5);
        pll_lock = 1'b0;
        wait_rel(6);
        pll_lock = 1'b1;
        chk_at("glitch_no_early", 10, o(0, 0, 0, 3'd0, 2'd0, 0));
        chk_at("glitch_last_wait", 15, o(0, 0, 0, 3'd0, 2'd0, 0));
        chk_at("glitch_clk_on", 16, o(1, 0, 0, 3'd1, 2'd0, 0));

        // Clock stop ignored in CLK_ON/CTRL_RST, honoured in CALIB
        do_reset(1'b1, 1'b0, 1'b0);
        wait_rel(10);
        ddr3_pll_stop = 1'b1;
        chk_at("stop_clk_on", 13, o(1, 0, 0, 3'd1, 2'd0, 0));
        chk_at("stop_ctrl_rst_a", 14, o(1, 0, 0, 3'd2, 2'd0, 0));
        chk_at("stop_ctrl_rst_b", 19, o(1, 0, 0, 3'd2, 2'd0, 0));
        chk_at("stop_calib_entry", 20, o(0, 1, 0, 3'd3, 2'd0, 0));
        wait_rel(30);
        ddr3_pll_stop = 1'b0;
        chk_at("stop_release_lat", 32, o(0, 1, 0, 3'd3, 2'd0, 0));
        chk_at("stop_released", 33, o(1, 1, 0, 3'd3, 2'd0, 0));
        wait_rel(40);
        ddr3_pll_stop = 1'b1;
        chk_at("calib_stop_lat", 42, o(1, 1, 0, 3'd3, 2'd0, 0));
        chk_at("calib_stop_lo", 43, o(0, 1, 0, 3'd3, 2'd0, 0));
        wait_rel(60);
        ddr3_pll_stop = 1'b0;
        chk_at("calib_stop_end", 62, o(0, 1, 0, 3'd3, 2'd0, 0));
        chk_at("calib_stop_hi", 63, o(1, 1, 0, 3'd3, 2'd0, 0));
        // Let it time out once, then async reset during the second CALIB
        chk_at("to1_before", 119, o(1, 1, 0, 3'd3, 2'd0, 0));
        chk_at("to1_retry", 120, o(0, 0, 0, 3'd0, 2'd1, 0));
        chk_at("to1_clk_on", 128, o(1, 0, 0, 3'd1, 2'd1, 0));
        chk_at("to1_calib", 150, o(1, 1, 0, 3'd3, 2'd1, 0));
        #2;
        cpu_reset = 1'b0;
        #1;
        check("async_reset_now", o(0, 0, 0, 3'd0, 2'd0, 0));
        repeat (2) @(negedge clk50);
        cpu_reset = 1'b1;
        base      = edge_cnt;
        check("rst_release", o(0, 0, 0, 3'd0, 2'd0, 0));
        chk_at("rst_wait", 9, o(0, 0, 0, 3'd0, 2'd0, 0));
        chk_at("rst_clk_on", 10, o(1, 0, 0, 3'd1, 2'd0, 0));
        chk_at("rst_calib", 20, o(1, 1, 0, 3'd3, 2'd0, 0));

        // Calibration never completes: retry then terminal fault
        do_reset(1'b1, 1'b0, 1'b0);
        chk_at("fault_to1", 120, o(0, 0, 0, 3'd0, 2'd1, 0));
        chk_at("fault_calib2", 138, o(1, 1, 0, 3'd3, 2'd1, 0));
        chk_at("fault_before", 237, o(1, 1, 0, 3'd3, 2'd1, 0));
        chk_at("fault_enter", 238, o(0, 0, 0, 3'd7, 2'd2, 1));
        wait_rel(240);
        pll_lock = 1'b0;
        wait_rel(245);
        pll_lock            = 1'b1;
        init_calib_complete = 1'b1;
        wait_rel(250);
        ddr3_pll_stop = 1'b1;
        chk_at("fault_held", 270, o(0, 0, 0, 3'd7, 2'd2, 1));
        do_reset(1'b1, 1'b0, 1'b0);
        check("fault_cleared", o(0, 0, 0, 3'd0, 2'd0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_reset_sequencer.md
# ddr3_reset_sequencer

Power-up and recovery sequencer for the DDR3 memory subsystem of the FPGA top level. It qualifies the PLL lock, enables the DDR3 memory clock output of the PLL, holds and releases the DDR3 controller reset, and waits for calibration. It releases the system (Briey) reset only once memory is usable, and retries or faults on calibration timeout or lock loss.

## Interface
Parameters:
- LOCK_FILTER, 1024: consecutive synchronized lock-high cycles required before enabling the memory clock.
- STOP_CYCLES, 16: cycles between memory-clock enable and start of controller reset hold.
- DDR_RST_CYCLES, 64: cycles the controller reset is held with the clock running.
- CALIB_TIMEOUT, 1048576: cycles allowed in CALIB before a retry.
- MAX_RETRIES, 3: retries allowed before FAULT (1..3).

Ports:
- clk50  in  1  sole clock, 50 MHz.
- cpu_reset  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL lock, asynchronous.
- ddr3_pll_stop  in  1  controller request to stop the memory clock, asynchronous.
- init_calib_complete  in  1  controller calibration done, asynchronous.
- ddr3_clk_en  out  1  to PLL enclk2; 1 = memory clock running.
- ddr_ctrl_rst_n  out  1  DDR3 controller reset, active low.
- sys_rst_n  out  1  system reset, active low (top level inverts it to io_asyncReset).
- seq_state  out  3  current state encoding.
- retry_count  out  2  calibration retries consumed.
- fault  out  1  sticky failure flag.

## Operation
- The 3 async inputs pass through 2-FF synchronizers clocked by clk50. Suffix _s denotes the synchronized value. No other logic sees the raw inputs.
- States and encodings: WAIT_LOCK=0, CLK_ON=1, CTRL_RST=2, CALIB=3, RUN=4, FAULT=7. A single timer is cleared on every state entry.
- WAIT_LOCK: clk_en=0, ctrl_rst_n=0, sys_rst_n=0.
  - The timer increments while pll_lock_s=1 and clears when pll_lock_s=0.
  - When the timer reaches LOCK_FILTER-1 with pll_lock_s=1, the state goes to CLK_ON.
- CLK_ON: clk_en=1. The state lasts exactly STOP_CYCLES cycles, then goes to CTRL_RST.
- CTRL_RST: clk_en=1, ctrl_rst_n=0. The state lasts exactly DDR_RST_CYCLES cycles, then goes to CALIB.
- CALIB: ctrl_rst_n=1, clk_en = ~ddr3_pll_stop_s.
  - If init_calib_complete_s=1, the state goes to RUN.
  - Otherwise, when the timer reaches CALIB_TIMEOUT-1, a retry occurs.
- RUN: sys_rst_n=1, ctrl_rst_n=1, clk_en = ~ddr3_pll_stop_s.
  - If init_calib_complete_s falls, a retry occurs.
- Retry: retry_count increments (saturating).
  - If the incremented value equals MAX_RETRIES, the state goes to FAULT.
  - Otherwise it goes to WAIT_LOCK.
- Lock loss: pll_lock_s=0 in CLK_ON, CTRL_RST, CALIB or RUN causes a transition to WAIT_LOCK. retry_count is not incremented.
- Priority: lock loss > calibration done > timeout/calibration loss.
- FAULT: fault=1, clk_en=0, ctrl_rst_n=0, sys_rst_n=0. The state is terminal until cpu_reset is asserted. Inputs are ignored.
- Reset (cpu_reset=0, at any time): all registers clear asynchronously.
  - Outputs: ddr3_clk_en=0, ddr_ctrl_rst_n=0, sys_rst_n=0, seq_state=0, retry_count=0, fault=0. The synchronizers clear to 0.
  - Reset mid-sequence abandons the sequence with no partial state retained.

## Timing
- All outputs are registered and reflect the current state. Each output changes on the clock edge that enters the new state.
- Input-to-decision latency is 2 cycles (synchronizer), plus 1 cycle to the registered output.
  - Example: pll_lock falling in RUN produces sys_rst_n=0 at most 3 clk50 edges later.
- The timer is wide enough for max(LOCK_FILTER, STOP_CYCLES, DDR_RST_CYCLES, CALIB_TIMEOUT)-1 and never wraps.
- Minimum time from cpu_reset release to sys_rst_n=1 is 2 + LOCK_FILTER + STOP_CYCLES + DDR_RST_CYCLES + 1 cycles, assuming calibration completes immediately.
- ddr3_pll_stop gating is honoured only in CALIB and RUN. In all other states clk_en is fixed by state.
- After cpu_reset release, the first transition is never taken before 2 edges have filled the synchronizers.

## Test plan
All scenarios use LOCK_FILTER=8, STOP_CYCLES=4, DDR_RST_CYCLES=6, CALIB_TIMEOUT=100, MAX_RETRIES=2.
- Nominal: lock high from reset, calib asserted 10 cycles into CALIB -> clk_en rises after 10 cycles, ctrl_rst_n rises 10 cycles later, sys_rst_n=1 at +13 (state 4), retry_count=0.
- Lock glitch: lock high 5 cycles, low 1 cycle, then high -> counter restarts, clk_en rises only after 8 further consecutive high samples.
- Calibration timeout: calib never asserted -> first timeout gives retry_count=1 and WAIT_LOCK; second timeout gives fault=1, state 7, outputs held in reset through any later lock/calib activity.
- Lock loss in RUN: drop pll_lock -> sys_rst_n, ctrl_rst_n, clk_en all 0 within 3 cycles, state 0, retry_count unchanged; restoring lock repeats the full sequence.
- Clock stop: in CALIB, pulse ddr3_pll_stop for 20 cycles -> clk_en low for 20 cycles (delayed 3), state stays 3; same pulse in CTRL_RST -> clk_en stays 1.
- Async reset mid-CALIB: assert cpu_reset between edges -> all outputs 0 immediately; on release the sequence restarts from WAIT_LOCK with retry_count=0.
